// File: rtl/demo_pwm.sv
// PWM generator slaved to an external 0..COUNT_MAX counter.
// Duty updates are staged and only applied on period boundaries.
module demo_pwm #(
    parameter int WIDTH     = 8,
    parameter int COUNT_MAX = 15
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic [WIDTH-1:0] Count,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             Pwm_out,
    output logic             period_done,
    output logic [15:0]      period_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] TOP      = WIDTH'(COUNT_MAX);
    localparam logic [WIDTH-1:0] DUTY_MAX = WIDTH'(COUNT_MAX + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] duty_active;
    logic [WIDTH-1:0] duty_pend;
    logic [WIDTH-1:0] duty_sat;
    logic             pend_valid;
    logic             boundary;
    logic             accept;
    logic             transfer;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (En)  state_nxt = RUN;
            RUN:     if (!En) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign boundary   = (state == RUN) && En && (Count == TOP);
    assign duty_ready = !pend_valid;
    assign accept     = duty_valid && duty_ready;
    // A staged value goes live immediately when idle, else only at the wrap.
    assign transfer   = pend_valid && ((state == IDLE) || boundary);
    assign duty_sat   = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= '0;
            duty_pend   <= '0;
            pend_valid  <= 1'b0;
        end else if (transfer) begin
            duty_active <= duty_pend;
            pend_valid  <= 1'b0;
        end else if (accept) begin
            duty_pend   <= duty_sat;
            pend_valid  <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            Pwm_out     <= 1'b0;
            period_done <= 1'b0;
            period_cnt  <= '0;
        end else begin
            Pwm_out     <= En && (Count < duty_active);
            period_done <= boundary;
            if (boundary && (period_cnt != 16'hFFFF))
                period_cnt <= period_cnt + 16'd1;
        end
    end

endmodule
